pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter LU_STALL_CYCLES, default 1, number of bubble cycles inserted on a load-use hazard (1..7).
REQ-002 SHALL have parameter MC_TIMEOUT, default 64, maximum cycles a multi-cycle EX op may hold the pipe before abort (2..255).
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have jump_flag_i  input  1  EX-stage redirect request, and jump_addr_i  input  32  redirect target.
REQ-006 SHALL have ex_is_load_i  input  1  and ex_rd_i  input  5: instruction in EX is a load writing ex_rd_i.
REQ-007 SHALL have id_rs1_i, id_rs2_i  input  5 each, and id_rs1_re_i, id_rs2_re_i  input  1 each: ID-stage source registers and their read enables.
REQ-008 SHALL have mc_start_i  input  1 (multi-cycle EX op starts this cycle) and mc_done_i  input  1 (result valid this cycle).
REQ-009 SHALL have hold_pc_o, hold_if_id_o, hold_id_ex_o  output  1 each: freeze the corresponding pipeline register.
REQ-010 SHALL have flush_if_id_o, flush_id_ex_o  output  1 each: load the NOP/zero reset value into the corresponding pipeline register.
REQ-011 SHALL have jump_flag_o  output  1 and jump_addr_o  output  32: redirect to PC register.
REQ-012 SHALL have state_o  output  2 (current FSM state) and mc_err_o  output  1 (sticky timeout flag).

Function
REQ-013 SHALL implement FSM states RUN, LU_STALL, MC_BUSY, JMP_FLUSH.
REQ-014 SHALL detect load-use hazard combinationally: ex_is_load_i && ex_rd_i!=0 && ((id_rs1_re_i && id_rs1_i==ex_rd_i) || (id_rs2_re_i && id_rs2_i==ex_rd_i)).
REQ-015 SHALL apply event priority, highest first: jump_flag_i, multi-cycle busy/start, load-use hazard.
REQ-016 SHALL, when jump_flag_i=1 in RUN or LU_STALL: drive jump_flag_o=1, jump_addr_o=jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1 in the same cycle (zero latency), holds=0, next state JMP_FLUSH.
REQ-017 SHALL, in JMP_FLUSH: flush_if_id_o=1 for exactly one cycle (covers 1-cycle fetch latency), then RUN; a new jump_flag_i in JMP_FLUSH restarts JMP_FLUSH.
REQ-018 SHALL drive jump_flag_o=0 and jump_addr_o=0 whenever jump_flag_i=0.
REQ-019 SHALL, on load-use hazard in RUN: hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1; load stall counter with LU_STALL_CYCLES-1; if 0, stay RUN, else go LU_STALL.
REQ-020 SHALL, in LU_STALL: keep the same three outputs asserted, decrement counter each cycle, return to RUN the cycle after counter reaches 0.
REQ-021 SHALL, on mc_start_i=1 in RUN with no jump: go MC_BUSY next cycle, clear timeout counter; mc_start_i is ignored in other states.
REQ-022 SHALL, in MC_BUSY: hold_pc_o=hold_if_id_o=hold_id_ex_o=1, flushes=0, timeout counter increments by 1 per cycle.
REQ-023 SHALL leave MC_BUSY to RUN on mc_done_i=1; holds deassert in that same cycle so the result advances.
REQ-024 SHALL, if the counter reaches MC_TIMEOUT-1 without mc_done_i: set mc_err_o=1 (sticky until reset), flush_id_ex_o=1 for that cycle, return to RUN.
REQ-025 SHALL honour jump_flag_i in MC_BUSY only together with mc_done_i (jump result of the op); jump_flag_i without mc_done_i in MC_BUSY is ignored.
REQ-026 SHALL never assert hold and flush on the same pipeline register in the same cycle; flush wins.
REQ-027 SHALL treat mc_done_i outside MC_BUSY as no-op.

Reset
REQ-028 SHALL, while rst=1, asynchronously force state RUN, all counters 0, mc_err_o=0, and all outputs 0 (state_o=RUN encoding 2'b00).
REQ-029 SHALL, when rst asserts mid-stall/busy/flush, abandon the operation with no residual hold or flush after rst deasserts.

Structure
REQ-030 SHALL place FSM state encodings, hold/flush enable/disable constants and the 32/5-bit bus widths in the shared defines file.
REQ-031 SHALL implement hazard comparison (REQ-014) in one combinational sub-module pipe_hzd; FSM, counters and output logic stay in pipe_ctrl.

Verification
REQ-032 SHALL cover: load x5 in EX, ID add reads rs2=x5, LU_STALL_CYCLES=1 -> one cycle hold_pc_o=hold_if_id_o=flush_id_ex_o=1, state stays RUN.
REQ-033 SHALL cover: same hazard with ex_rd_i=0 or id_rs2_re_i=0 -> no hold, no flush.
REQ-034 SHALL cover: jump_flag_i=1, jump_addr_i=0x0000_0100 -> same cycle jump_flag_o=1, addr 0x100, both flushes; next cycle flush_if_id_o only; then RUN.
REQ-035 SHALL cover: mc_start_i, mc_done_i after 34 cycles -> 34 busy cycles all holds=1, holds 0 on done cycle, mc_err_o=0.
REQ-036 SHALL cover: mc_start_i, no done, MC_TIMEOUT=8 -> mc_err_o=1 after 8 cycles, flush_id_ex_o pulse, RUN; mc_err_o stays 1 until rst.
REQ-037 SHALL cover: rst pulse during MC_BUSY -> all outputs 0 immediately, state_o=RUN after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// State encodings, hold/flush levels, bus widths and the control bundle.
package pipe_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_LU_STALL  = 2'b01,
    ST_MC_BUSY   = 2'b10,
    ST_JMP_FLUSH = 2'b11
  } state_e;

  localparam logic HOLD_EN   = 1'b1;
  localparam logic HOLD_DIS  = 1'b0;
  localparam logic FLUSH_EN  = 1'b1;
  localparam logic FLUSH_DIS = 1'b0;

  typedef struct packed {
    logic hold_pc;
    logic hold_if_id;
    logic hold_id_ex;
    logic flush_if_id;
    logic flush_id_ex;
    logic jump;
  } ctrl_t;

endpackage

// File: rtl/pipe_hzd.sv
// Load-use hazard detector: a load in EX writes a register ID reads.
// Ports: EX load/rd, ID rs1/rs2 with read enables -> lu_hzd_o.
module pipe_hzd
  import pipe_ctrl_pkg::*;
(
  input  logic             ex_is_load_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_rs1_re_i,
  input  logic             id_rs2_re_i,
  output logic             lu_hzd_o
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = id_rs1_re_i && (id_rs1_i == ex_rd_i);
  assign w_rs2_hit = id_rs2_re_i && (id_rs2_i == ex_rd_i);
  // x0 is never a real dependency
  assign lu_hzd_o  = ex_is_load_i && (ex_rd_i != '0) &&
                     (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control FSM: jump flush, load-use stall, multi-cycle EX hold.
// Ports: hazard/jump/mc inputs -> hold/flush/jump outputs, state, mc_err.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int MC_TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              ex_is_load_i,
  input  logic [REG_W-1:0]  ex_rd_i,
  input  logic [REG_W-1:0]  id_rs1_i,
  input  logic [REG_W-1:0]  id_rs2_i,
  input  logic              id_rs1_re_i,
  input  logic              id_rs2_re_i,
  input  logic              mc_start_i,
  input  logic              mc_done_i,
  output logic              hold_pc_o,
  output logic              hold_if_id_o,
  output logic              hold_id_ex_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic [1:0]        state_o,
  output logic              mc_err_o
);

  localparam logic [2:0] LU_INIT = 3'(LU_STALL_CYCLES - 1);
  localparam logic [7:0] MC_MAX  = 8'(MC_TIMEOUT - 1);

  state_e     r_state, w_nxt;
  logic [2:0] r_lu_cnt, w_lu_cnt;
  logic [7:0] r_mc_cnt, w_mc_cnt;
  logic       r_mc_err, w_mc_err;
  logic       w_hzd;
  logic       w_tmo;
  logic       w_act;
  ctrl_t      w_ctl;

  pipe_hzd u_hzd (
    .ex_is_load_i (ex_is_load_i),
    .ex_rd_i      (ex_rd_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_rs1_re_i  (id_rs1_re_i),
    .id_rs2_re_i  (id_rs2_re_i),
    .lu_hzd_o     (w_hzd)
  );

  assign w_tmo = (r_mc_cnt == MC_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_lu_cnt <= '0;
      r_mc_cnt <= '0;
      r_mc_err <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_lu_cnt <= w_lu_cnt;
      r_mc_cnt <= w_mc_cnt;
      r_mc_err <= w_mc_err;
    end
  end

  always_comb begin
    w_nxt    = r_state;
    w_lu_cnt = r_lu_cnt;
    w_mc_cnt = r_mc_cnt;
    w_mc_err = r_mc_err;
    unique case (r_state)
      ST_RUN: begin
        if (jump_flag_i) begin
          w_nxt = ST_JMP_FLUSH;
        end else if (mc_start_i) begin
          w_nxt    = ST_MC_BUSY;
          w_mc_cnt = '0;
        end else if (w_hzd) begin
          w_lu_cnt = LU_INIT;
          w_nxt    = (LU_INIT == '0) ? ST_RUN : ST_LU_STALL;
        end
      end
      ST_LU_STALL: begin
        if (jump_flag_i) begin
          w_nxt = ST_JMP_FLUSH;
        end else begin
          w_lu_cnt = (r_lu_cnt == '0) ? '0 : r_lu_cnt - 3'd1;
          // last bubble when the count is about to hit zero
          if (r_lu_cnt <= 3'd1) w_nxt = ST_RUN;
        end
      end
      ST_MC_BUSY: begin
        if (mc_done_i) begin
          w_nxt = jump_flag_i ? ST_JMP_FLUSH : ST_RUN;
        end else if (w_tmo) begin
          w_mc_err = 1'b1;
          w_nxt    = ST_RUN;
        end else begin
          w_mc_cnt = r_mc_cnt + 8'd1;
        end
      end
      ST_JMP_FLUSH: begin
        w_nxt = jump_flag_i ? ST_JMP_FLUSH : ST_RUN;
      end
      default: w_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_ctl = '{HOLD_DIS, HOLD_DIS, HOLD_DIS,
              FLUSH_DIS, FLUSH_DIS, 1'b0};
    unique case (r_state)
      ST_RUN, ST_LU_STALL: begin
        if (jump_flag_i) begin
          w_ctl.jump        = 1'b1;
          w_ctl.flush_if_id = FLUSH_EN;
          w_ctl.flush_id_ex = FLUSH_EN;
        end else if ((r_state == ST_LU_STALL) ||
                     (!mc_start_i && w_hzd)) begin
          w_ctl.hold_pc     = HOLD_EN;
          w_ctl.hold_if_id  = HOLD_EN;
          w_ctl.flush_id_ex = FLUSH_EN;
        end
      end
      ST_MC_BUSY: begin
        if (mc_done_i) begin
          // holds drop so the result advances; jump only with done
          if (jump_flag_i) begin
            w_ctl.jump        = 1'b1;
            w_ctl.flush_if_id = FLUSH_EN;
            w_ctl.flush_id_ex = FLUSH_EN;
          end
        end else if (w_tmo) begin
          w_ctl.flush_id_ex = FLUSH_EN;
        end else begin
          w_ctl.hold_pc    = HOLD_EN;
          w_ctl.hold_if_id = HOLD_EN;
          w_ctl.hold_id_ex = HOLD_EN;
        end
      end
      ST_JMP_FLUSH: begin
        w_ctl.flush_if_id = FLUSH_EN;
        if (jump_flag_i) begin
          w_ctl.jump        = 1'b1;
          w_ctl.flush_id_ex = FLUSH_EN;
        end
      end
      default: ;
    endcase
  end

  // outputs are forced low while reset is held, whatever the inputs do
  assign w_act         = ~rst;
  assign hold_pc_o     = w_act & w_ctl.hold_pc;
  assign hold_if_id_o  = w_act & w_ctl.hold_if_id & ~w_ctl.flush_if_id;
  assign hold_id_ex_o  = w_act & w_ctl.hold_id_ex & ~w_ctl.flush_id_ex;
  assign flush_if_id_o = w_act & w_ctl.flush_if_id;
  assign flush_id_ex_o = w_act & w_ctl.flush_id_ex;
  assign jump_flag_o   = w_act & w_ctl.jump;
  assign jump_addr_o   = (w_act & w_ctl.jump) ? jump_addr_i : '0;
  assign state_o       = r_state;
  assign mc_err_o      = r_mc_err;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance plus LU=2/TIMEOUT=8.
// Outputs packed as {state, hpc, hifid, hidex, fifid, fidex, jmp, err}.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jf;
  logic [31:0] ja;
  logic        ld;
  logic [4:0]  rd, rs1, rs2;
  logic        re1, re2;
  logic        mcs, mcd;

  logic        hp0, hi0, he0, fi0, fe0, jf0, er0;
  logic [31:0] ja0;
  logic [1:0]  st0;
  logic        hp1, hi1, he1, fi1, fe1, jf1, er1;
  logic [31:0] ja1;
  logic [1:0]  st1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl u0 (
    .clk(clk), .rst(rst), .jump_flag_i(jf), .jump_addr_i(ja),
    .ex_is_load_i(ld), .ex_rd_i(rd), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_re_i(re1), .id_rs2_re_i(re2),
    .mc_start_i(mcs), .mc_done_i(mcd),
    .hold_pc_o(hp0), .hold_if_id_o(hi0), .hold_id_ex_o(he0),
    .flush_if_id_o(fi0), .flush_id_ex_o(fe0),
    .jump_flag_o(jf0), .jump_addr_o(ja0),
    .state_o(st0), .mc_err_o(er0)
  );

  pipe_ctrl #(.LU_STALL_CYCLES(2), .MC_TIMEOUT(8)) u1 (
    .clk(clk), .rst(rst), .jump_flag_i(jf), .jump_addr_i(ja),
    .ex_is_load_i(ld), .ex_rd_i(rd), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_re_i(re1), .id_rs2_re_i(re2),
    .mc_start_i(mcs), .mc_done_i(mcd),
    .hold_pc_o(hp1), .hold_if_id_o(hi1), .hold_id_ex_o(he1),
    .flush_if_id_o(fi1), .flush_id_ex_o(fe1),
    .jump_flag_o(jf1), .jump_addr_o(ja1),
    .state_o(st1), .mc_err_o(er1)
  );

  wire [8:0] o0 = {st0, hp0, hi0, he0, fi0, fe0, jf0, er0};
  wire [8:0] o1 = {st1, hp1, hi1, he1, fi1, fe1, jf1, er1};

  localparam logic [8:0] ZERO  = 9'b00_0000000;
  localparam logic [8:0] LUSTL = 9'b00_1100100;
  localparam logic [8:0] LUST1 = 9'b01_1100100;
  localparam logic [8:0] JMP0  = 9'b00_0001110;
  localparam logic [8:0] JMPF  = 9'b11_0001000;
  localparam logic [8:0] JMPR  = 9'b11_0001110;
  localparam logic [8:0] BUSY  = 9'b10_1110000;
  localparam logic [8:0] DONE  = 9'b10_0000000;
  localparam logic [8:0] TMO   = 9'b10_0000100;
  localparam logic [8:0] ERR   = 9'b00_0000001;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    jf = 0; ja = '0; ld = 0; rd = '0; rs1 = '0; rs2 = '0;
    re1 = 0; re2 = 0; mcs = 0; mcd = 0;
  endtask

  // advance to the next cycle; inputs are applied 1 after the edge
  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic hzd(input logic [4:0] d, input logic [4:0] a,
                     input logic [4:0] b, input logic ea,
                     input logic eb);
    ld = 1; rd = d; rs1 = a; rs2 = b; re1 = ea; re2 = eb;
  endtask

  initial begin
    idle();
    rst = 1;
    jf = 1; ja = 32'hdead_beef;
    #12;
    chk("rst_out0", 32'(o0), 32'(ZERO));
    chk("rst_addr0", ja0, 32'h0);
    chk("rst_out1", 32'(o1), 32'(ZERO));
    @(posedge clk); #1;
    rst = 0;
    idle();

    // load x5, ID add reads rs2=x5
    nxt(); hzd(5'd5, 5'd3, 5'd5, 1, 1); #2;
    chk("lu_rs2_0", 32'(o0), 32'(LUSTL));
    chk("lu_rs2_1", 32'(o1), 32'(LUSTL));
    nxt(); #2;
    chk("lu_after0", 32'(o0), 32'(ZERO));
    chk("lu_2nd1", 32'(o1), 32'(LUST1));
    nxt(); hzd(5'd0, 5'd3, 5'd0, 1, 1); #2;
    chk("lu_x0_0", 32'(o0), 32'(ZERO));
    chk("lu_x0_1", 32'(o1), 32'(ZERO));
    nxt(); hzd(5'd5, 5'd3, 5'd5, 1, 0); #2;
    chk("lu_nore0", 32'(o0), 32'(ZERO));
    nxt(); hzd(5'd7, 5'd7, 5'd1, 1, 1); #2;
    chk("lu_rs1_0", 32'(o0), 32'(LUSTL));
    nxt(); #2;
    nxt(); #2;
    chk("lu_clr0", 32'(o0), 32'(ZERO));
    chk("lu_clr1", 32'(o1), 32'(ZERO));

    // jump with a simultaneous hazard: jump wins
    nxt(); jf = 1; ja = 32'h0000_0100; hzd(5'd5, 5'd5, 5'd0, 1, 0); #2;
    chk("jmp_out", 32'(o0), 32'(JMP0));
    chk("jmp_addr", ja0, 32'h100);
    nxt(); #2;
    chk("jmp_fl", 32'(o0), 32'(JMPF));
    chk("jmp_fl_addr", ja0, 32'h0);
    nxt(); #2;
    chk("jmp_run", 32'(o0), 32'(ZERO));
    nxt(); jf = 1; ja = 32'h0000_0200; #2;
    chk("jj_1", 32'(o0), 32'(JMP0));
    nxt(); jf = 1; ja = 32'h0000_0300; #2;
    chk("jj_2", 32'(o0), 32'(JMPR));
    chk("jj_2addr", ja0, 32'h300);
    nxt(); #2;
    chk("jj_fl", 32'(o0), 32'(JMPF));
    nxt(); #2;
    chk("jj_run", 32'(o0), 32'(ZERO));

    // multi-cycle op: done after 34 busy cycles on u0, timeout on u1
    nxt(); mcs = 1; #2;
    chk("mc_start", 32'(o0), 32'(ZERO));
    for (int i = 0; i < 34; i++) begin
      nxt();
      if (i == 3) begin jf = 1; ja = 32'h0000_0400; end
      #2;
      chk($sformatf("mc_busy0_%0d", i), 32'(o0), 32'(BUSY));
      if (i < 7)
        chk($sformatf("mc_busy1_%0d", i), 32'(o1), 32'(BUSY));
      else if (i == 7)
        chk("mc_tmo1", 32'(o1), 32'(TMO));
      else
        chk($sformatf("mc_err1_%0d", i), 32'(o1), 32'(ERR));
    end
    nxt(); mcd = 1; #2;
    chk("mc_done0", 32'(o0), 32'(DONE));
    chk("mc_done_run1", 32'(o1), 32'(ERR));
    nxt(); #2;
    chk("mc_after0", 32'(o0), 32'(ZERO));
    chk("mc_after1", 32'(o1), 32'(ERR));

    // reset pulse mid-busy
    nxt(); mcs = 1; #2;
    nxt(); #2;
    nxt(); #2;
    chk("pre_rst0", 32'(o0), 32'(BUSY));
    jf = 1; ja = 32'h0000_0500;
    rst = 1; #1;
    chk("rst_mid0", 32'(o0), 32'(ZERO));
    chk("rst_mid1", 32'(o1), 32'(ZERO));
    chk("rst_mid_addr", ja0, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    idle(); #2;
    chk("rst_rel0", 32'(o0), 32'(ZERO));
    nxt(); #2;
    chk("rst_rel0b", 32'(o0), 32'(ZERO));
    chk("rst_rel1", 32'(o1), 32'(ZERO));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
